// File: rtl/mux4_rr_sel_arbiter_if.sv
// mux4_rr_sel_arbiter_if: request/select handshake between four requesters, the arbiter and the mux consumer
interface mux4_rr_sel_arbiter_if;
   logic [3:0] req;
   logic       out_ready;
   logic       out_valid;
   logic [1:0] sel;
   logic [3:0] grant;
   modport master (input req, out_ready, output out_valid, sel, grant);
   modport slave  (output req, out_ready, input out_valid, sel, grant);
endinterface

// File: rtl/mux4_rr_sel_arbiter.sv
// mux4_rr_sel_arbiter: round-robin 4:1 mux select arbiter with valid/ready handshake and burst cap
module mux4_rr_sel_arbiter #(
   parameter int MAX_BURST = 4
) (
   input logic clk,
   input logic rst_n,
   mux4_rr_sel_arbiter_if.master bus
);
   localparam int CW = $clog2(MAX_BURST + 1);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t        state, state_n;
   logic [1:0]    rr_ptr, ptr_n, sel, sel_n, arb_ptr, win;
   logic [3:0]    grant, grant_n;
   logic          valid, valid_n, found, beat, stay;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   assign bus.out_valid = valid;
   assign bus.sel       = sel;
   assign bus.grant     = grant;
   assign beat    = valid & bus.out_ready;
   assign cnt_inc = cnt + CW'(1);
   // on release the holder becomes the pointer, so it is scanned last
   assign arb_ptr = (state == GRANT) ? sel : rr_ptr;
   always_comb begin
      found = 1'b0;
      win   = 2'd0;
      for (int i = 4; i >= 1; i--) begin
         if (bus.req[arb_ptr + 2'(i)]) begin
            found = 1'b1;
            win   = arb_ptr + 2'(i);
         end
      end
   end
   assign stay = (state == GRANT) && bus.req[sel] && (!beat || cnt_inc < CW'(MAX_BURST));
   always_comb begin
      state_n = state;
      ptr_n   = rr_ptr;
      sel_n   = sel;
      grant_n = grant;
      valid_n = valid;
      cnt_n   = cnt;
      if (stay) begin
         cnt_n = beat ? cnt_inc : cnt;
      end else begin
         ptr_n   = (state == GRANT) ? sel : rr_ptr;
         state_n = found ? GRANT : IDLE;
         valid_n = found;
         sel_n   = found ? win : sel;
         grant_n = found ? (4'b0001 << win) : 4'b0000;
         cnt_n   = '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= 2'd3;
         sel    <= 2'd0;
         grant  <= 4'b0000;
         valid  <= 1'b0;
         cnt    <= '0;
      end else begin
         state  <= state_n;
         rr_ptr <= ptr_n;
         sel    <= sel_n;
         grant  <= grant_n;
         valid  <= valid_n;
         cnt    <= cnt_n;
      end
   end
endmodule

// File: tb/tb_mux4_rr_sel_arbiter.sv
// tb_mux4_rr_sel_arbiter: directed vectors for the arbiter with burst caps of 4 and 1
module tb_mux4_rr_sel_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vecs = 0;
   int   errs = 0;
   mux4_rr_sel_arbiter_if b4 ();
   mux4_rr_sel_arbiter_if b1 ();
   mux4_rr_sel_arbiter #(.MAX_BURST(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   mux4_rr_sel_arbiter #(.MAX_BURST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic do_reset();
      b4.req = 4'h0;
      b1.req = 4'h0;
      b4.out_ready = 1'b0;
      b1.out_ready = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask
   initial begin
      logic [1:0] seq3 [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
      b4.req = 4'h0;
      b1.req = 4'h0;
      b4.out_ready = 1'b0;
      b1.out_ready = 1'b0;
      step();
      chk("rst_valid", 32'(b4.out_valid), 0);
      chk("rst_sel", 32'(b4.sel), 0);
      chk("rst_grant", 32'(b4.grant), 0);
      b4.req = 4'hF;
      rst_n = 1'b1;
      step();
      chk("t1_first_grant", 32'(b4.grant), 32'h1);
      chk("t1_first_valid", 32'(b4.out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_async_valid", 32'(b4.out_valid), 0);
      chk("t1_async_sel", 32'(b4.sel), 0);
      chk("t1_async_grant", 32'(b4.grant), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("t1_regrant", 32'(b4.grant), 32'h1);
      do_reset();
      b1.req = 4'hF;
      b1.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         chk("t2_rr_sel", 32'(b1.sel), 32'(i % 4));
         chk("t2_rr_valid", 32'(b1.out_valid), 1);
         chk("t2_rr_grant", 32'(b1.grant), 32'(4'b0001 << (i % 4)));
      end
      do_reset();
      b4.req = 4'b0101;
      b4.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t3_burst_sel", 32'(b4.sel), 32'(seq3[i]));
         chk("t3_burst_valid", 32'(b4.out_valid), 1);
      end
      do_reset();
      b4.req = 4'b0010;
      step();
      chk("t4_sel1", 32'(b4.sel), 1);
      b4.req = 4'hF;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_stall_sel", 32'(b4.sel), 1);
         chk("t4_stall_grant", 32'(b4.grant), 32'h2);
         chk("t4_stall_valid", 32'(b4.out_valid), 1);
      end
      b4.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t4_resume_sel", 32'(b4.sel), (i < 3) ? 32'd1 : 32'd2);
      end
      do_reset();
      b4.req = 4'b1000;
      step();
      chk("t5_sel3", 32'(b4.sel), 3);
      chk("t5_grant3", 32'(b4.grant), 32'h8);
      b4.req = 4'b0000;
      step();
      chk("t5_idle_valid", 32'(b4.out_valid), 0);
      chk("t5_idle_grant", 32'(b4.grant), 0);
      b4.req = 4'b1001;
      step();
      chk("t5_next_grant", 32'(b4.grant), 32'h1);
      chk("t5_next_sel", 32'(b4.sel), 0);
      do_reset();
      b4.req = 4'b0010;
      b4.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t6_single_sel", 32'(b4.sel), 1);
         chk("t6_single_valid", 32'(b4.out_valid), 1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
